// File: rtl/wb_write_queue_pkg.sv
// Shared register-file geometry and write-queue defaults for the WB write path.
// Entry type matches one pending register write at the default widths.
package wb_write_queue_pkg;
  localparam int REG_W     = 3;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int WBQ_DEPTH = 4;

  typedef struct packed {
    logic [REG_W-1:0]  regSel;
    logic [DATA_W-1:0] data;
  } wbqEntry_t;
endpackage

// File: rtl/wb_write_queue_fwd.sv
// Forwarding lookup: newest valid queue entry matching one read select, combinational.
// No state; no backpressure.
module wbq_fwd_match #(
  parameter int DEPTH  = wb_write_queue_pkg::WBQ_DEPTH,
  parameter int REG_W  = wb_write_queue_pkg::REG_W,
  parameter int DATA_W = wb_write_queue_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][REG_W-1:0]  entryReg,
  input  logic [DEPTH-1:0][DATA_W-1:0] entryData,
  input  logic [DEPTH-1:0]             entryValid,
  input  logic [PTR_W-1:0]             headPtr,
  input  logic [REG_W-1:0]             sel,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);
  import wb_write_queue_pkg::*;

  // Walk oldest to newest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = headPtr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PTR_W'(i);
      if (entryValid[idx] && (entryReg[idx] == sel)) begin
        hit  = 1'b1;
        data = entryData[idx];
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// WB write queue feeding the register file's single write port, with two forwarding lookups.
// Latency: accepted at edge E, written to rf at edge E+1; wbReady drops only when all entries are full.
module wb_write_queue #(
  parameter int DEPTH  = wb_write_queue_pkg::WBQ_DEPTH,
  parameter int REG_W  = wb_write_queue_pkg::REG_W,
  parameter int DATA_W = wb_write_queue_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbValid,
  input  logic [REG_W-1:0]  wbReg,
  input  logic [DATA_W-1:0] wbData,
  output logic              wbReady,
  output logic              writeEn,
  output logic [REG_W-1:0]  writeRegSel,
  output logic [DATA_W-1:0] writeData,
  input  logic [REG_W-1:0]  readReg1Sel,
  input  logic [REG_W-1:0]  readReg2Sel,
  output logic              fwdHit1,
  output logic [DATA_W-1:0] fwdData1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData2,
  output logic [CNT_W-1:0]  count,
  output logic              err
);
  import wb_write_queue_pkg::*;

  logic [DEPTH-1:0][REG_W-1:0]  entryReg;
  logic [DEPTH-1:0][DATA_W-1:0] entryData;
  logic [DEPTH-1:0]             entryValid;
  logic [PTR_W-1:0]             headPtr;
  logic [PTR_W-1:0]             tailPtr;
  logic                         enq;
  logic                         deq;

  assign wbReady = (count != CNT_W'(DEPTH));
  assign enq     = wbValid & wbReady;
  assign deq     = (count != '0);

  // The rf always takes the head, so a non-empty queue pops every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
      entryValid <= '0;
      entryReg   <= '0;
      entryData  <= '0;
    end else begin
      if (deq) begin
        entryValid[headPtr] <= 1'b0;
        headPtr             <= headPtr + PTR_W'(1);
      end
      if (enq) begin
        entryReg[tailPtr]   <= wbReg;
        entryData[tailPtr]  <= wbData;
        entryValid[tailPtr] <= 1'b1;
        tailPtr             <= tailPtr + PTR_W'(1);
      end
      if (enq && !deq) begin
        count <= count + CNT_W'(1);
      end else if (!enq && deq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign writeEn     = deq;
  assign writeRegSel = deq ? entryReg[headPtr] : '0;
  assign writeData   = deq ? entryData[headPtr] : '0;

  wbq_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) uFwd1 (
    .entryReg   (entryReg),
    .entryData  (entryData),
    .entryValid (entryValid),
    .headPtr    (headPtr),
    .sel        (readReg1Sel),
    .hit        (fwdHit1),
    .data       (fwdData1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) uFwd2 (
    .entryReg   (entryReg),
    .entryData  (entryData),
    .entryValid (entryValid),
    .headPtr    (headPtr),
    .sel        (readReg2Sel),
    .hit        (fwdHit2),
    .data       (fwdData2)
  );

  // Simulation-visible flag for unknown inputs; constant 0 in two-state hardware.
  assign err = ((^{clk, rst, wbValid, wbReg, wbData, readReg1Sel, readReg2Sel}) === 1'bx);
endmodule
